// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-ported memory. Data normally wins contention, but after a run of
// contested data grants the fetch port is given one turn so it cannot starve.
// Every access is bounded by a timeout so a silent memory cannot hang a port.
module mem_arbiter #(
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_tmoCount;
  logic [3:0]  r_streak;

  logic        w_grantI;
  logic        w_grantD;
  logic [7:0]  w_tmoNext;
  logic        w_tmoExpire;
  logic [3:0]  w_streakNext;

  // Grant decision for the IDLE state plus next values of both counters.
  always_comb begin
    w_grantI     = 1'b0;
    w_grantD     = 1'b0;
    w_tmoNext    = r_tmoCount + 8'd1;
    w_tmoExpire  = (w_tmoNext == TMO_LIMIT);
    w_streakNext = (r_streak >= STREAK_MAX) ? STREAK_MAX : (r_streak + 4'd1);
    if (i_req && d_req) begin
      if (r_streak == STREAK_MAX) begin
        w_grantI = 1'b1;
      end else begin
        w_grantD = 1'b1;
      end
    end else if (d_req) begin
      w_grantD = 1'b1;
    end else if (i_req) begin
      w_grantI = 1'b1;
    end
  end

  // Arbiter FSM; every port-visible signal is a register written here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_tmoCount <= 8'd0;
      r_streak   <= 4'd0;
      i_rdata    <= 32'd0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= 32'd0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wmask  <= 4'd0;
      mem_rstrb  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantI) begin
            r_state    <= BUSY_I;
            r_tmoCount <= 8'd0;
            r_streak   <= 4'd0;
            mem_valid  <= 1'b1;
            mem_addr   <= i_addr;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
            mem_rstrb  <= 1'b1;
          end else if (w_grantD) begin
            r_state    <= BUSY_D;
            r_tmoCount <= 8'd0;
            r_streak   <= i_req ? w_streakNext : 4'd0;
            mem_valid  <= 1'b1;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_wmask  <= d_wmask;
            mem_rstrb  <= (d_wmask == 4'd0);
          end
        end

        BUSY_I: begin
          if (mem_ready) begin
            r_state   <= DONE;
            i_rdata   <= mem_rdata;
            i_done    <= 1'b1;
            i_err     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rstrb <= 1'b0;
          end else begin
            r_tmoCount <= w_tmoNext;
            if (w_tmoExpire) begin
              r_state   <= DONE;
              i_rdata   <= 32'd0;
              i_done    <= 1'b1;
              i_err     <= 1'b1;
              mem_valid <= 1'b0;
              mem_rstrb <= 1'b0;
            end
          end
        end

        BUSY_D: begin
          if (mem_ready) begin
            r_state   <= DONE;
            if (mem_rstrb) begin
              d_rdata <= mem_rdata;
            end
            d_done    <= 1'b1;
            d_err     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rstrb <= 1'b0;
          end else begin
            r_tmoCount <= w_tmoNext;
            if (w_tmoExpire) begin
              r_state   <= DONE;
              d_rdata   <= 32'd0;
              d_done    <= 1'b1;
              d_err     <= 1'b1;
              mem_valid <= 1'b0;
              mem_rstrb <= 1'b0;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          i_done  <= 1'b0;
          i_err   <= 1'b0;
          d_done  <= 1'b0;
          d_err   <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
